// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the CPU main-memory port arbiter.
package cpu_mem_pkg;

    localparam int unsigned MEM_AW = 16;
    localparam int unsigned MEM_DW = 16;

    typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;
    typedef enum logic {OWN_IF, OWN_D} owner_t;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Combinational two-way picker between instruction fetch and the data path.
module rr_arb2
    import cpu_mem_pkg::*;
(
    input  logic req_if,
    input  logic req_d,
    input  logic last_owner,
    input  logic fixed_prio,
    output logic winner
);

    // winner/last_owner carry the owner_t encoding: 1 = data path.
    always_comb begin
        winner = OWN_IF;
        if (req_if && req_d)
            winner = (fixed_prio || last_owner == OWN_IF) ? OWN_D : OWN_IF;
        else if (req_d)
            winner = OWN_D;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IF reads and D reads/writes onto the single-port main memory,
// aborting with an error response when the memory never acknowledges.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int unsigned AW          = MEM_AW,
    parameter int unsigned DW          = MEM_DW,
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter bit          FIXED_PRIO  = 1'b0
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          err,
    output logic          busy
);

    localparam int unsigned   CW       = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    state_t        state_q, state_d;
    owner_t        owner_q, owner_d, last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          win_bit;

    logic          if_gnt_d, if_rvalid_d, d_gnt_d, d_rvalid_d;
    logic          mem_req_d, mem_we_d, err_d, busy_d;
    logic [AW-1:0] mem_addr_d;
    logic [DW-1:0] mem_wdata_d, if_rdata_d, d_rdata_d;

    rr_arb2 u_arb (
        .req_if     (if_req),
        .req_d      (d_req),
        .last_owner (last_q),
        .fixed_prio (FIXED_PRIO),
        .winner     (win_bit)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        if_gnt_d    = 1'b0;
        d_gnt_d     = 1'b0;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        err_d       = 1'b0;
        mem_req_d   = mem_req;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        if_rdata_d  = if_rdata;
        d_rdata_d   = d_rdata;
        busy_d      = busy;
        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    owner_d     = owner_t'(win_bit);
                    last_d      = owner_t'(win_bit);
                    state_d     = MEM;
                    cnt_d       = '0;
                    busy_d      = 1'b1;
                    mem_req_d   = 1'b1;
                    if_gnt_d    = !win_bit;
                    d_gnt_d     = win_bit;
                    mem_we_d    = win_bit && d_we;
                    mem_addr_d  = win_bit ? d_addr : if_addr;
                    mem_wdata_d = win_bit ? d_wdata : '0;
                end
            end
            MEM: begin
                // An ack on the final timeout cycle still counts as a normal completion.
                if (mem_ack || cnt_q == CNT_LAST) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    err_d     = !mem_ack;
                    if (owner_q == OWN_D) begin
                        d_rvalid_d = 1'b1;
                        if (!mem_we)
                            d_rdata_d = mem_ack ? mem_rdata : '0;
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = mem_ack ? mem_rdata : '0;
                    end
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            owner_q   <= OWN_IF;
            last_q    <= OWN_D;
            cnt_q     <= '0;
            if_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            d_gnt     <= 1'b0;
            d_rvalid  <= 1'b0;
            d_rdata   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            if_gnt    <= if_gnt_d;
            if_rvalid <= if_rvalid_d;
            if_rdata  <= if_rdata_d;
            d_gnt     <= d_gnt_d;
            d_rvalid  <= d_rvalid_d;
            d_rdata   <= d_rdata_d;
            mem_req   <= mem_req_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            err       <= err_d;
            busy      <= busy_d;
        end
    end

endmodule
